// File: rtl/mpu_pkg.sv
// ---------------------------------------------------------------------------
// mpu_pkg
// Purpose : Shared definitions for the MPU TileLink checker: TL channel
//           types, TL opcode constants, region table entry type,
//           permission bit positions and the opcode/permission helper.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package mpu_pkg;

    `include "mpu_common.svh"

    // A-channel opcodes
    localparam logic [2:0] TL_GET         = 3'd4;
    localparam logic [2:0] TL_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;

    // D-channel opcodes
    localparam logic [2:0] TL_ACK      = 3'd0;
    localparam logic [2:0] TL_ACK_DATA = 3'd1;

    // Bit positions inside the {W,R} permission field
    localparam int PERM_R = 0;
    localparam int PERM_W = 1;

    // The TL source field is 4 bits wide, so the mask never needs more
    // than 16 bits; narrower core counts just leave the upper bits zero.
    localparam int MAX_CORES = 16;

    typedef struct packed {
        logic                 en;
        logic [31:0]          base;
        logic [31:0]          limit;
        logic [1:0]           perm;
        logic [MAX_CORES-1:0] core_mask;
    } region_cfg_t;

    // Reads need R, both put flavours need W; every other opcode is refused.
    function automatic logic perm_ok(input logic [2:0] opcode, input logic [1:0] perm);
        case (opcode)
            TL_GET:                      return perm[PERM_R];
            TL_PUT_FULL, TL_PUT_PARTIAL: return perm[PERM_W];
            default:                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mpu_common.svh
// ---------------------------------------------------------------------------
// mpu_common.svh
// Purpose : TileLink A- and D-channel beat types shared by the MPU checker,
//           its memory-side neighbour and the arbiter. This file is included
//           inside package mpu_pkg, so users see the types as
//           mpu_pkg::tl_a_channel and mpu_pkg::tl_d_channel.
// Ports   : none (type definitions only)
// ---------------------------------------------------------------------------
`ifndef MPU_COMMON_SVH
`define MPU_COMMON_SVH

typedef struct packed {
    logic        valid;
    logic [2:0]  opcode;
    logic [31:0] address;
    logic [31:0] data;
    logic [3:0]  source;
} tl_a_channel;

typedef struct packed {
    logic [2:0]  opcode;
    logic [31:0] address;
    logic [31:0] data;
    logic [3:0]  source;
} tl_d_channel;

`endif

// File: rtl/mpu_region_match.sv
// ---------------------------------------------------------------------------
// mpu_region_match
// Purpose : Combinational priority matcher. Finds the lowest-index enabled
//           region whose core mask covers the requesting core and whose
//           inclusive [base, limit] range covers the address, then reports
//           whether that region grants the permission the opcode needs.
// Ports   : i_regions  - region table
//           i_opcode   - latched request opcode
//           i_address  - latched request address
//           i_core     - requesting core id (low bits of TL source)
//           o_hit      - some region matched
//           o_allow    - the winning region grants the access
//           o_hit_idx  - index of the winning region
// ---------------------------------------------------------------------------
module mpu_region_match
    import mpu_pkg::*;
#(
    parameter int NUM_REGIONS  = 8,
    parameter int REGION_IDX_W = 3,
    parameter int CORE_ID_W    = 2
) (
    input  region_cfg_t             i_regions [NUM_REGIONS],
    input  logic [2:0]              i_opcode,
    input  logic [31:0]             i_address,
    input  logic [CORE_ID_W-1:0]    i_core,
    output logic                    o_hit,
    output logic                    o_allow,
    output logic [REGION_IDX_W-1:0] o_hit_idx
);

    // Scan from the top index down so the lowest hitting index is written
    // last and wins. An entry with base > limit can never satisfy both
    // compares, so it never hits.
    always_comb begin
        o_hit     = 1'b0;
        o_allow   = 1'b0;
        o_hit_idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (i_regions[i].en &&
                i_regions[i].core_mask[i_core] &&
                (i_address >= i_regions[i].base) &&
                (i_address <= i_regions[i].limit)) begin
                o_hit     = 1'b1;
                o_allow   = perm_ok(i_opcode, i_regions[i].perm);
                o_hit_idx = REGION_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mpu_tl_checker.sv
// ---------------------------------------------------------------------------
// mpu_tl_checker
// Purpose : Sits behind the TileLink request arbiter. Accepts one A-channel
//           request at a time, checks it against a per-core region
//           permission table, then either forwards it to memory or answers
//           it locally with a denied D-channel response. Memory D beats pass
//           straight through and always take priority over a denial.
// Ports   : clk, rst_n            - clock, async active-low reset
//           in_req / in_ready     - A request from arbiter / accept strobe
//           cfg_*                 - region table write port
//           mem_req / mem_ready   - A request to memory / memory accept
//           mem_resp, mem_d_valid - D response from memory
//           mem_d_ready           - constant 1
//           out_resp, out_d_valid - D response toward arbiter
//           out_denied            - out_resp is an access fault
// Optional: MPU_FAULT_LOG_EN adds fault_addr, fault_source, fault_count,
//           fault_irq (outputs) and fault_clr (input), a log of emitted
//           denials with a sticky interrupt.
// ---------------------------------------------------------------------------
module mpu_tl_checker
    import mpu_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int NUM_REGIONS  = 8,
    parameter int REGION_IDX_W = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  tl_a_channel             in_req,
    output logic                    in_ready,
    input  logic                    cfg_we,
    input  logic [REGION_IDX_W-1:0] cfg_idx,
    input  logic                    cfg_en,
    input  logic [31:0]             cfg_base,
    input  logic [31:0]             cfg_limit,
    input  logic [1:0]              cfg_perm,
    input  logic [NUM_CORES-1:0]    cfg_core_mask,
    output tl_a_channel             mem_req,
    input  logic                    mem_ready,
    input  tl_d_channel             mem_resp,
    input  logic                    mem_d_valid,
    output logic                    mem_d_ready,
    output tl_d_channel             out_resp,
    output logic                    out_d_valid,
    output logic                    out_denied
`ifdef MPU_FAULT_LOG_EN
    ,
    output logic [31:0]             fault_addr,
    output logic [3:0]              fault_source,
    output logic [15:0]             fault_count,
    output logic                    fault_irq,
    input  logic                    fault_clr
`endif
);

    localparam int CORE_ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FWD,
        ST_DENY
    } state_t;

    state_t      r_state;
    logic        r_in_ready;
    tl_a_channel r_req;
    tl_a_channel r_mem_req;
    tl_d_channel r_deny_resp;
    region_cfg_t r_regions [NUM_REGIONS];

    logic        w_hit;
    logic        w_allow;
    logic        w_deny_fire;

    // Region table; a write becomes visible to the matcher the cycle after
    // it lands, so a check running in the write cycle sees the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                r_regions[i] <= '0;
            end
        end else if (cfg_we) begin
            r_regions[cfg_idx] <= '{en:        cfg_en,
                                    base:      cfg_base,
                                    limit:     cfg_limit,
                                    perm:      cfg_perm,
                                    core_mask: MAX_CORES'(cfg_core_mask)};
        end
    end

    mpu_region_match #(
        .NUM_REGIONS  (NUM_REGIONS),
        .REGION_IDX_W (REGION_IDX_W),
        .CORE_ID_W    (CORE_ID_W)
    ) u_match (
        .i_regions (r_regions),
        .i_opcode  (r_req.opcode),
        .i_address (r_req.address),
        .i_core    (r_req.source[CORE_ID_W-1:0]),
        .o_hit     (w_hit),
        .o_allow   (w_allow),
        .o_hit_idx ()
    );

    // Request FSM. The latched request always carries valid=1 (it was only
    // captured on a handshake), so it can be copied into mem_req unchanged.
    // The denial beat is prepared during CHECK so DENY only has to wait for
    // a gap in the memory response stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_req       <= '0;
            r_mem_req   <= '0;
            r_deny_resp <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_req.valid && r_in_ready) begin
                        r_req      <= in_req;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_CHECK;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    r_deny_resp.opcode  <= (r_req.opcode == TL_GET) ? TL_ACK_DATA : TL_ACK;
                    r_deny_resp.address <= r_req.address;
                    r_deny_resp.data    <= '0;
                    r_deny_resp.source  <= r_req.source;
                    if (w_hit && w_allow) begin
                        r_mem_req <= r_req;
                        r_state   <= ST_FWD;
                    end else begin
                        r_state   <= ST_DENY;
                    end
                end
                ST_FWD: begin
                    if (mem_ready) begin
                        r_mem_req  <= '0;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_DENY: begin
                    if (!mem_d_valid) begin
                        r_in_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The denial fires in the first DENY cycle with no memory beat present.
    assign w_deny_fire = (r_state == ST_DENY) && !mem_d_valid;

    // D merge: memory beats pass through with zero latency and win over a
    // pending denial, which simply waits in DENY.
    always_comb begin
        out_resp    = '0;
        out_d_valid = 1'b0;
        out_denied  = 1'b0;
        if (mem_d_valid) begin
            out_resp    = mem_resp;
            out_d_valid = 1'b1;
        end else if (w_deny_fire) begin
            out_resp    = r_deny_resp;
            out_d_valid = 1'b1;
            out_denied  = 1'b1;
        end
    end

    assign in_ready    = r_in_ready;
    assign mem_req     = r_mem_req;
    assign mem_d_ready = 1'b1;

`ifdef MPU_FAULT_LOG_EN
    logic [31:0] r_fault_addr;
    logic [3:0]  r_fault_source;
    logic [15:0] r_fault_count;
    logic        r_fault_irq;

    // Fault log. A denial emitted in the same cycle as a clear wins, so the
    // log restarts at one fault with the interrupt raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault_addr   <= '0;
            r_fault_source <= '0;
            r_fault_count  <= '0;
            r_fault_irq    <= 1'b0;
        end else if (w_deny_fire) begin
            r_fault_addr   <= r_deny_resp.address;
            r_fault_source <= r_deny_resp.source;
            r_fault_irq    <= 1'b1;
            if (fault_clr) begin
                r_fault_count <= 16'd1;
            end else if (r_fault_count != 16'hFFFF) begin
                r_fault_count <= r_fault_count + 16'd1;
            end
        end else if (fault_clr) begin
            r_fault_count <= '0;
            r_fault_irq   <= 1'b0;
        end
    end

    assign fault_addr   = r_fault_addr;
    assign fault_source = r_fault_source;
    assign fault_count  = r_fault_count;
    assign fault_irq    = r_fault_irq;
`endif

endmodule

// File: tb/tb_mpu_tl_checker.sv
// ---------------------------------------------------------------------------
// tb_mpu_tl_checker
// Purpose : Directed self-checking bench for mpu_tl_checker. Each task
//           drives one scenario and compares outputs against hand-computed
//           values. Inputs change and outputs are sampled 1ns after the
//           rising edge.
// ---------------------------------------------------------------------------
module tb_mpu_tl_checker;
    import mpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    tl_a_channel in_req;
    logic        in_ready;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic        cfg_en;
    logic [31:0] cfg_base;
    logic [31:0] cfg_limit;
    logic [1:0]  cfg_perm;
    logic [3:0]  cfg_core_mask;
    tl_a_channel mem_req;
    logic        mem_ready;
    tl_d_channel mem_resp;
    logic        mem_d_valid;
    logic        mem_d_ready;
    tl_d_channel out_resp;
    logic        out_d_valid;
    logic        out_denied;
`ifdef MPU_FAULT_LOG_EN
    logic [31:0] fault_addr;
    logic [3:0]  fault_source;
    logic [15:0] fault_count;
    logic        fault_irq;
    logic        fault_clr = 1'b0;
`endif

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    mpu_tl_checker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_req        (in_req),
        .in_ready      (in_ready),
        .cfg_we        (cfg_we),
        .cfg_idx       (cfg_idx),
        .cfg_en        (cfg_en),
        .cfg_base      (cfg_base),
        .cfg_limit     (cfg_limit),
        .cfg_perm      (cfg_perm),
        .cfg_core_mask (cfg_core_mask),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .mem_resp      (mem_resp),
        .mem_d_valid   (mem_d_valid),
        .mem_d_ready   (mem_d_ready),
        .out_resp      (out_resp),
        .out_d_valid   (out_d_valid),
        .out_denied    (out_denied)
`ifdef MPU_FAULT_LOG_EN
        ,
        .fault_addr    (fault_addr),
        .fault_source  (fault_source),
        .fault_count   (fault_count),
        .fault_irq     (fault_irq),
        .fault_clr     (fault_clr)
`endif
    );

    // Advance to 1ns past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a region write for one cycle; it is visible from the next cycle.
    task automatic cfg_write(input logic [2:0] idx, input logic en, input logic [31:0] base,
                             input logic [31:0] limit, input logic [1:0] perm, input logic [3:0] mask);
        cfg_we        = 1'b1;
        cfg_idx       = idx;
        cfg_en        = en;
        cfg_base      = base;
        cfg_limit     = limit;
        cfg_perm      = perm;
        cfg_core_mask = mask;
        step();
        cfg_we        = 1'b0;
    endtask

    // Present a request until accepted (bounded). Returns 1ns after the
    // accepting edge, i.e. in the CHECK cycle.
    task automatic send_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] dat,
                            input logic [3:0] src, output bit ok);
        in_req = '{valid: 1'b1, opcode: op, address: addr, data: dat, source: src};
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        in_req = '0;
    endtask

    // Reset values of every output while reset is held and just after it.
    task automatic test_reset();
        nTests++; if (in_ready !== 1'b0) begin nFail++; $display("[TB] FAIL reset_in_ready: got %b, expected 0", in_ready); end
        nTests++; if (mem_req !== '0) begin nFail++; $display("[TB] FAIL reset_mem_req: got %h, expected 0", mem_req); end
        nTests++; if (out_d_valid !== 1'b0 || out_denied !== 1'b0) begin nFail++; $display("[TB] FAIL reset_out_flags: got %b%b, expected 00", out_d_valid, out_denied); end
        nTests++; if (out_resp !== '0) begin nFail++; $display("[TB] FAIL reset_out_resp: got %h, expected 0", out_resp); end
        rst_n = 1'b1;
        step();
        nTests++; if (in_ready !== 1'b1) begin nFail++; $display("[TB] FAIL reset_release_ready: got %b, expected 1", in_ready); end
    endtask

    // Allowed Get is forwarded at T+2 and held stable under backpressure.
    task automatic test_get_forward();
        bit ok;
        tl_a_channel exp;
        exp = '{valid: 1'b1, opcode: TL_GET, address: 32'h1800, data: 32'hCAFE_0001, source: 4'd0};
        cfg_write(3'd0, 1'b1, 32'h1000, 32'h1FFF, 2'b01, 4'b0001);
        mem_ready = 1'b0;
        send_req(TL_GET, 32'h1800, 32'hCAFE_0001, 4'd0, ok);
        nTests++; if (!ok) begin nFail++; $display("[TB] FAIL fwd_accept: got timeout, expected accept"); end
        nTests++; if (mem_req.valid !== 1'b0 || in_ready !== 1'b0) begin nFail++; $display("[TB] FAIL fwd_check_cycle: got valid=%b ready=%b, expected 0 0", mem_req.valid, in_ready); end
        step();
        nTests++; if (mem_req !== exp) begin nFail++; $display("[TB] FAIL fwd_t2: got %h, expected %h", mem_req, exp); end
        for (int i = 0; i < 3; i++) begin
            step();
            nTests++; if (mem_req !== exp) begin nFail++; $display("[TB] FAIL fwd_hold%0d: got %h, expected %h", i, mem_req, exp); end
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        nTests++; if (mem_req.valid !== 1'b0 || in_ready !== 1'b1) begin nFail++; $display("[TB] FAIL fwd_done: got valid=%b ready=%b, expected 0 1", mem_req.valid, in_ready); end
    endtask

    // Put to a read-only region is answered locally for exactly one cycle.
    task automatic test_put_denied();
        bit ok;
        tl_d_channel exp;
        exp = '{opcode: TL_ACK, address: 32'h1800, data: 32'h0, source: 4'd0};
        send_req(TL_PUT_FULL, 32'h1800, 32'h1234_5678, 4'd0, ok);
        nTests++; if (!ok || out_d_valid !== 1'b0) begin nFail++; $display("[TB] FAIL put_check_cycle: got ok=%b dv=%b, expected 1 0", ok, out_d_valid); end
        step();
        nTests++; if (out_d_valid !== 1'b1 || out_denied !== 1'b1 || out_resp !== exp) begin nFail++; $display("[TB] FAIL put_deny: got dv=%b den=%b %h, expected 1 1 %h", out_d_valid, out_denied, out_resp, exp); end
        nTests++; if (mem_req.valid !== 1'b0) begin nFail++; $display("[TB] FAIL put_no_mem: got %b, expected 0", mem_req.valid); end
        step();
        nTests++; if (out_d_valid !== 1'b0 || in_ready !== 1'b1) begin nFail++; $display("[TB] FAIL put_one_cycle: got dv=%b ready=%b, expected 0 1", out_d_valid, in_ready); end
    endtask

    // Core mask gates a hit; a region for core 2 then lets the retry through.
    task automatic test_core_mask();
        bit ok;
        tl_d_channel exp;
        exp = '{opcode: TL_ACK_DATA, address: 32'h1800, data: 32'h0, source: 4'd2};
        send_req(TL_GET, 32'h1800, 32'h0, 4'd2, ok);
        step();
        nTests++; if (!ok || out_denied !== 1'b1 || out_resp !== exp) begin nFail++; $display("[TB] FAIL mask_deny: got ok=%b den=%b %h, expected 1 1 %h", ok, out_denied, out_resp, exp); end
        step();
        cfg_write(3'd1, 1'b1, 32'h0, 32'hFFFF, 2'b11, 4'b0100);
        mem_ready = 1'b1;
        send_req(TL_GET, 32'h1800, 32'h0, 4'd2, ok);
        step();
        nTests++; if (!ok || mem_req.valid !== 1'b1 || mem_req.source !== 4'd2 || out_d_valid !== 1'b0) begin nFail++; $display("[TB] FAIL mask_retry: got ok=%b valid=%b src=%h dv=%b, expected 1 1 2 0", ok, mem_req.valid, mem_req.source, out_d_valid); end
        step();
        mem_ready = 1'b0;
        nTests++; if (mem_req.valid !== 1'b0) begin nFail++; $display("[TB] FAIL mask_retry_done: got %b, expected 0", mem_req.valid); end
    endtask

    // Memory beats pass through and stall a pending denial.
    task automatic test_passthrough_stall();
        bit ok;
        tl_d_channel beat;
        tl_d_channel exp;
        exp = '{opcode: TL_ACK, address: 32'h9000, data: 32'h0, source: 4'd1};
        send_req(TL_PUT_FULL, 32'h9000, 32'hFFFF_0000, 4'd1, ok);
        nTests++; if (!ok) begin nFail++; $display("[TB] FAIL stall_accept: got timeout, expected accept"); end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            beat = '{opcode: 3'(k), address: 32'h100 + 32'(k), data: 32'hD0 + 32'(k), source: 4'(k + 4)};
            mem_resp    = beat;
            mem_d_valid = 1'b1;
            #1;
            nTests++; if (out_d_valid !== 1'b1 || out_denied !== 1'b0 || out_resp !== beat) begin nFail++; $display("[TB] FAIL stall_pass%0d: got dv=%b den=%b %h, expected 1 0 %h", k, out_d_valid, out_denied, out_resp, beat); end
        end
        step();
        mem_d_valid = 1'b0;
        mem_resp    = '0;
        #1;
        nTests++; if (out_d_valid !== 1'b1 || out_denied !== 1'b1 || out_resp !== exp) begin nFail++; $display("[TB] FAIL stall_deny: got dv=%b den=%b %h, expected 1 1 %h", out_d_valid, out_denied, out_resp, exp); end
        step();
        nTests++; if (out_d_valid !== 1'b0) begin nFail++; $display("[TB] FAIL stall_deny_once: got %b, expected 0", out_d_valid); end
    endtask

    // Priority, inclusive limit, inverted range, unknown opcode and a config
    // write racing the check.
    task automatic test_priority();
        bit ok;
        cfg_write(3'd2, 1'b1, 32'h4000, 32'h4FFF, 2'b01, 4'b1111);
        cfg_write(3'd5, 1'b1, 32'h3000, 32'h5000, 2'b11, 4'b1111);
        cfg_write(3'd6, 1'b1, 32'h8000, 32'h7000, 2'b11, 4'b1111);
        send_req(TL_PUT_PARTIAL, 32'h4000, 32'h0, 4'd3, ok);
        step();
        nTests++; if (!ok || out_denied !== 1'b1 || out_resp.opcode !== TL_ACK || mem_req.valid !== 1'b0) begin nFail++; $display("[TB] FAIL prio_put: got den=%b op=%0d mv=%b, expected 1 0 0", out_denied, out_resp.opcode, mem_req.valid); end
        step();
        mem_ready = 1'b1;
        send_req(TL_GET, 32'h4000, 32'h0, 4'd3, ok);
        step();
        nTests++; if (!ok || mem_req.valid !== 1'b1 || mem_req.address !== 32'h4000) begin nFail++; $display("[TB] FAIL prio_get: got valid=%b addr=%h, expected 1 4000", mem_req.valid, mem_req.address); end
        step();
        send_req(TL_PUT_FULL, 32'h5000, 32'h0, 4'd3, ok);
        step();
        nTests++; if (!ok || mem_req.valid !== 1'b1 || mem_req.address !== 32'h5000) begin nFail++; $display("[TB] FAIL limit_inclusive: got valid=%b addr=%h, expected 1 5000", mem_req.valid, mem_req.address); end
        step();
        send_req(TL_GET, 32'h7800, 32'h0, 4'd3, ok);
        step();
        nTests++; if (!ok || out_denied !== 1'b1 || out_resp.opcode !== TL_ACK_DATA) begin nFail++; $display("[TB] FAIL inverted_range: got den=%b op=%0d, expected 1 1", out_denied, out_resp.opcode); end
        step();
        send_req(3'd2, 32'h4800, 32'h0, 4'd3, ok);
        step();
        nTests++; if (!ok || out_denied !== 1'b1 || out_resp.opcode !== TL_ACK) begin nFail++; $display("[TB] FAIL bad_opcode: got den=%b op=%0d, expected 1 0", out_denied, out_resp.opcode); end
        step();
        send_req(TL_GET, 32'h9000, 32'h0, 4'd0, ok);
        cfg_write(3'd7, 1'b1, 32'h9000, 32'h9FFF, 2'b11, 4'b0001);
        nTests++; if (!ok || out_denied !== 1'b1 || mem_req.valid !== 1'b0) begin nFail++; $display("[TB] FAIL cfg_race: got den=%b mv=%b, expected 1 0", out_denied, mem_req.valid); end
        step();
        send_req(TL_GET, 32'h9000, 32'h0, 4'd0, ok);
        step();
        nTests++; if (!ok || mem_req.valid !== 1'b1 || mem_req.address !== 32'h9000) begin nFail++; $display("[TB] FAIL cfg_after: got valid=%b addr=%h, expected 1 9000", mem_req.valid, mem_req.address); end
        step();
        mem_ready = 1'b0;
    endtask

    // Reset during FWD drops the request at once and clears the table.
    task automatic test_reset_mid();
        bit ok;
        send_req(TL_GET, 32'h5000, 32'h0, 4'd3, ok);
        step();
        nTests++; if (!ok || mem_req.valid !== 1'b1) begin nFail++; $display("[TB] FAIL rstmid_fwd: got ok=%b valid=%b, expected 1 1", ok, mem_req.valid); end
        rst_n = 1'b0;
        #1;
        nTests++; if (mem_req.valid !== 1'b0 || in_ready !== 1'b0) begin nFail++; $display("[TB] FAIL rstmid_async: got valid=%b ready=%b, expected 0 0", mem_req.valid, in_ready); end
        step();
        step();
        rst_n = 1'b1;
        step();
        nTests++; if (in_ready !== 1'b1) begin nFail++; $display("[TB] FAIL rstmid_ready: got %b, expected 1", in_ready); end
        mem_ready = 1'b1;
        send_req(TL_GET, 32'h5000, 32'h0, 4'd3, ok);
        step();
        nTests++; if (!ok || out_denied !== 1'b1 || mem_req.valid !== 1'b0) begin nFail++; $display("[TB] FAIL rstmid_cleared: got den=%b mv=%b, expected 1 0", out_denied, mem_req.valid); end
        step();
        mem_ready = 1'b0;
    endtask

    initial begin
        in_req        = '0;
        cfg_we        = 1'b0;
        cfg_idx       = '0;
        cfg_en        = 1'b0;
        cfg_base      = '0;
        cfg_limit     = '0;
        cfg_perm      = '0;
        cfg_core_mask = '0;
        mem_ready     = 1'b0;
        mem_resp      = '0;
        mem_d_valid   = 1'b0;
        step();
        step();
        test_reset();
        test_get_forward();
        test_put_denied();
        test_core_mask();
        test_passthrough_stall();
        test_priority();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
